// File: rtl/cla_serial_alu_ctrl.sv
// Nibble-serial two's-complement add/subtract sequencer around one shared 4-bit CLA.
// Processes NIBBLES slices LSB first, registering the carry between slices.

module cla_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic       mode,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] bx;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        bx   = b ^ {4{mode}};
        g    = a & bx;
        p    = a ^ bx;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum   = p ^ c[3:0];
        c_out = c[4];
    end
endmodule

// Handshake: start is a request taken on any edge where the block is not busy
// (IDLE or DONE); done is a one-cycle valid strobe with no backpressure.
module cla_serial_alu_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 c_out,
    output logic                 overflow,
    output logic [1:0]           state_dbg
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             mode_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_next;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       add_sum;
    logic             add_c;

    // The controller inverts B itself; the shared adder always runs in add mode.
    always_comb begin
        a_nib    = a_q[{idx, 2'b00} +: 4];
        b_nib    = b_q[{idx, 2'b00} +: 4] ^ {4{mode_q}};
        acc_next = acc;
        acc_next[{idx, 2'b00} +: 4] = add_sum;
    end

    cla_adder_4 u_cla (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .mode  (1'b0),
        .sum   (add_sum),
        .c_out (add_c)
    );

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        carry  <= mode;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    carry <= add_c;
                    if (idx == LAST) begin
                        // On the last slice the nibble operands are the MSB nibbles.
                        result   <= acc_next;
                        c_out    <= add_c;
                        overflow <= (a_nib[3] == b_nib[3]) && (add_sum[3] != a_nib[3]);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_serial_alu_ctrl.sv
// Scoreboard bench for cla_serial_alu_ctrl: directed vectors, expected results queued
// by the driver and popped by a monitor whenever done pulses.

module tb_cla_serial_alu_ctrl;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         reset;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;
    logic [1:0]   state_dbg;

    logic [W+1:0] exp_q[$];
    int           n_checks;
    int           n_pass;
    int           cyc;

    cla_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("busy_done_exclusive", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result_cout_ovf", {46'd0, result, c_out, overflow}, {46'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic issue(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit push, input logic [W-1:0] er, input logic ec, input logic eo);
        @(posedge clk);
        #1;
        mode  = m;
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back({er, ec, eo});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        at_cyc = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen   = 1;
                at_cyc = cyc;
            end
        end
        if (!seen) check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic op(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] er, input logic ec, input logic eo);
        int t;
        issue(m, av, bv, 1'b1, er, ec, eo);
        wait_done(t);
    endtask

    initial begin
        int e0;
        int d1;
        int d2;
        int busy_cnt;
        int done_cnt;
        int n;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {45'd0, busy, done, result, c_out, overflow}, 64'd0);
        check("reset_state", {62'd0, state_dbg}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // add with busy-length and latency measurement
        issue(1'b0, 16'h1234, 16'h0FCD, 1'b1, 16'h2201, 1'b0, 1'b0);
        e0 = cyc;
        busy_cnt = 0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("busy_cycles", 64'(busy_cnt), 64'd4);
        check("latency", 64'(cyc - e0), 64'd4);

        // carry / overflow boundaries
        op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        op(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        op(1'b1, 16'h0005, 16'h0002, 16'h0003, 1'b1, 1'b0);
        op(1'b1, 16'h0002, 16'h0005, 16'hFFFD, 1'b0, 1'b0);
        op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        op(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);

        // result holds through IDLE
        repeat (3) @(negedge clk);
        check("result_hold", {46'd0, result, c_out, overflow}, {46'd0, 16'h0000, 1'b1, 1'b0});

        // start held high, operands changed mid-RUN, back-to-back from DONE
        @(posedge clk);
        #1;
        mode  = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        exp_q.push_back({16'h3333, 1'b0, 1'b0});
        exp_q.push_back({16'h1010, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        a = 16'h0F0F;
        b = 16'h0101;
        wait_done(d1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_b2b_start", {63'd0, busy}, 64'd1);
        wait_done(d2);
        check("done_spacing", 64'(d2 - d1), 64'd5);

        // reset during the 2nd RUN cycle aborts the operation
        issue(1'b0, 16'h1234, 16'h0FCD, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", {46'd0, result, c_out, overflow}, 64'd0);
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        // reset and start in the same cycle
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        a     = 16'h4444;
        b     = 16'h1111;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("collision_busy", {63'd0, busy}, 64'd0);
        check("collision_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        check("collision_idle_later", {62'd0, busy, done}, 64'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
